// File: rtl/edge_tick_array_pkg.sv
// Shared types for the edge tick array: per-channel FSM states, edge modes,
// and helpers that decide whether a given mode reports a rising or falling edge.
package edge_tick_array_pkg;

  typedef enum logic [1:0] {
    ST_ZERO  = 2'd0,
    ST_WAIT1 = 2'd1,
    ST_ONE   = 2'd2,
    ST_WAIT0 = 2'd3
  } state_e;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  function automatic logic rise_en(input logic [1:0] mode);
    return (mode == MODE_RISE) || (mode == MODE_BOTH);
  endfunction

  function automatic logic fall_en(input logic [1:0] mode);
    return (mode == MODE_FALL) || (mode == MODE_BOTH);
  endfunction

endpackage

// File: rtl/edge_tick_array_if.sv
// Bundle of the per-channel level inputs, mode/clear controls and tick/flag outputs.
// The master side drives levels and controls; the slave side is the tick array.
interface edge_tick_array_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] level;
  logic [1:0]          mode;
  logic [CHANNELS-1:0] clr;
  logic [CHANNELS-1:0] tick;
  logic                tick_any;
  logic [CHANNELS-1:0] level_db;
  logic [CHANNELS-1:0] event_flg;

  modport master (
    output level, mode, clr,
    input  tick, tick_any, level_db, event_flg
  );

  modport slave (
    input  level, mode, clr,
    output tick, tick_any, level_db, event_flg
  );
endinterface

// File: rtl/edge_tick_array_chan.sv
// One channel: synchroniser, debounce FSM, registered tick and sticky event flag.
// Tick appears SYNC_STAGES+DEBOUNCE edges after the raw level change is first sampled.
module edge_tick_array_chan
  import edge_tick_array_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int CNT_W       = 3
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       level_i,
  input  logic [1:0] mode_i,
  input  logic       clr_i,
  output logic       tick_o,
  output logic       tick_d_o,
  output logic       level_db_o,
  output logic       event_flg_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   tick_q;
  logic                   tick_d;
  logic                   flg_q;
  logic                   s;
  logic                   cnt_done;

  assign s        = sync_q[SYNC_STAGES-1];
  assign cnt_done = (cnt_q == CNT_MAX);

  // Exposed so the top can register tick_any in the same cycle as tick.
  always_comb begin
    tick_d = 1'b0;
    if (state_q == ST_WAIT1 && s && cnt_done) begin
      tick_d = rise_en(mode_i);
    end else if (state_q == ST_WAIT0 && !s && cnt_done) begin
      tick_d = fall_en(mode_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q  <= '0;
      state_q <= ST_ZERO;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      flg_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], level_i};
      tick_q <= tick_d;
      // A tick landing together with clr keeps the flag set.
      flg_q  <= tick_q | (flg_q & ~clr_i);
      case (state_q)
        ST_ZERO: begin
          if (s) begin
            state_q <= ST_WAIT1;
            cnt_q   <= '0;
          end
        end
        ST_WAIT1: begin
          if (!s) begin
            state_q <= ST_ZERO;
            cnt_q   <= '0;
          end else if (cnt_done) begin
            state_q <= ST_ONE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_ONE: begin
          if (!s) begin
            state_q <= ST_WAIT0;
            cnt_q   <= '0;
          end
        end
        ST_WAIT0: begin
          if (s) begin
            state_q <= ST_ONE;
            cnt_q   <= '0;
          end else if (cnt_done) begin
            state_q <= ST_ZERO;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign tick_o      = tick_q;
  assign tick_d_o    = tick_d;
  assign level_db_o  = (state_q == ST_ONE) || (state_q == ST_WAIT0);
  assign event_flg_o = flg_q;

endmodule

// File: rtl/edge_tick_array.sv
// N independent debounced level-to-tick channels plus a registered OR of all ticks.
// tick_any is aligned with tick; there is no backpressure, ticks are never stored.
module edge_tick_array #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int CNT_W       = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  edge_tick_array_if.slave   bus
);

  logic [CHANNELS-1:0] tick_d;
  logic                tick_any_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    edge_tick_array_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE    (DEBOUNCE),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .level_i     (bus.level[g]),
      .mode_i      (bus.mode),
      .clr_i       (bus.clr[g]),
      .tick_o      (bus.tick[g]),
      .tick_d_o    (tick_d[g]),
      .level_db_o  (bus.level_db[g]),
      .event_flg_o (bus.event_flg[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tick_any_q <= 1'b0;
    end else begin
      tick_any_q <= |tick_d;
    end
  end

  assign bus.tick_any = tick_any_q;

endmodule

// File: tb/tb_edge_tick_array.sv
// Randomised and directed stimulus against a run-length reference model; a
// negedge monitor pops expected outputs from a scoreboard queue and compares.
module tb_edge_tick_array;

  localparam int CH  = 4;
  localparam int DEB = 4;

  typedef struct {
    int         cyc;
    logic [3:0] tick;
    logic [3:0] any;
    logic [3:0] db;
    logic [3:0] flg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  edge_tick_array_if #(.CHANNELS(CH)) bus ();

  edge_tick_array #(
    .CHANNELS    (CH),
    .SYNC_STAGES (2),
    .DEBOUNCE    (DEB),
    .CNT_W       (3)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  // Reference model: debounced level flips once the synchronised input has
  // disagreed with it on DEB+1 consecutive edges.
  logic [3:0] m_hist[$] = '{4'h0, 4'h0};
  logic [3:0] m_db   = '0;
  logic [3:0] m_tick = '0;
  logic [3:0] m_flag = '0;
  int         m_run[CH];
  exp_t       exp_q[$];
  int         n_cyc  = 0;
  int         n_chk  = 0;
  int         n_fail = 0;
  int         n_ticks = 0;

  task automatic model_edge(input logic [3:0] lv, input logic [1:0] md,
                            input logic [3:0] cl, input logic rs);
    exp_t       e;
    logic [3:0] s;
    logic [3:0] nt;
    nt = '0;
    if (rs) begin
      m_hist = '{4'h0, 4'h0};
      m_db   = '0;
      m_flag = '0;
      for (int c = 0; c < CH; c++) m_run[c] = 0;
    end else begin
      s = m_hist.pop_front();
      m_hist.push_back(lv);
      m_flag = m_tick | (m_flag & ~cl);
      for (int c = 0; c < CH; c++) begin
        m_run[c] = (s[c] != m_db[c]) ? m_run[c] + 1 : 0;
        if (m_run[c] == DEB + 1) begin
          m_run[c] = 0;
          m_db[c]  = ~m_db[c];
          nt[c]    = m_db[c] ? (md == 2'b00 || md == 2'b10)
                             : (md == 2'b01 || md == 2'b10);
        end
      end
    end
    m_tick = nt;
    n_ticks += $countones(nt);
    e.cyc  = n_cyc;
    e.tick = m_tick;
    e.any  = {3'b0, |m_tick};
    e.db   = m_db;
    e.flg  = m_flag;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic [3:0] lv, input logic [1:0] md,
                     input logic [3:0] cl, input logic rs);
    bus.level = lv;
    bus.mode  = md;
    bus.clr   = cl;
    rst       = rs;
    @(posedge clk);
    n_cyc++;
    model_edge(lv, md, cl, rs);
    #1;
  endtask

  task automatic chk(input string nm, input int c, input logic [3:0] act,
                     input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, c, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tick",      e.cyc, bus.tick,               e.tick);
        chk("tick_any",  e.cyc, {3'b0, bus.tick_any},   e.any);
        chk("level_db",  e.cyc, bus.level_db,           e.db);
        chk("event_flg", e.cyc, bus.event_flg,          e.flg);
      end
    end
  end

  initial begin : driver
    logic [3:0] lv;
    logic [1:0] md;
    logic [3:0] cl;
    logic       pend;
    logic       t;
    int         hold[CH];

    bus.level = '0;
    bus.mode  = 2'b00;
    bus.clr   = '0;

    // Reset, then a held rise on channel 0.
    repeat (2) cyc(4'b0000, 2'b00, 4'b0000, 1'b1);
    repeat (10) cyc(4'b0001, 2'b00, 4'b0000, 1'b0);
    // Three-cycle glitch on channel 1.
    repeat (3) cyc(4'b0011, 2'b00, 4'b0000, 1'b0);
    repeat (8) cyc(4'b0001, 2'b00, 4'b0000, 1'b0);
    // Channel 2 pulse under both, falling-only and disabled modes.
    for (int m = 0; m < 3; m++) begin
      md = (m == 0) ? 2'b10 : (m == 1) ? 2'b01 : 2'b11;
      repeat (10) cyc(4'b0101, md, 4'b0000, 1'b0);
      repeat (10) cyc(4'b0001, md, 4'b0000, 1'b0);
    end
    // Simultaneous edges on channels 0 and 3.
    repeat (10) cyc(4'b0000, 2'b10, 4'b0000, 1'b0);
    repeat (10) cyc(4'b1001, 2'b10, 4'b0000, 1'b0);
    repeat (10) cyc(4'b0000, 2'b00, 4'b1111, 1'b0);
    // clr coincident with tick, then clr the following cycle.
    pend = 1'b0;
    for (int i = 0; i < 12; i++) begin
      t = m_tick[0];
      cyc(4'b0001, 2'b00, {3'b000, t | pend}, 1'b0);
      pend = t;
    end
    // Reset mid-debounce with the level held high.
    repeat (10) cyc(4'b0000, 2'b00, 4'b0000, 1'b0);
    repeat (5) cyc(4'b0001, 2'b00, 4'b0000, 1'b0);
    cyc(4'b0001, 2'b00, 4'b0000, 1'b1);
    repeat (12) cyc(4'b0001, 2'b00, 4'b0000, 1'b0);

    // Random phase: per-channel hold lengths straddle the debounce threshold.
    lv = 4'b0001;
    md = 2'b00;
    for (int c = 0; c < CH; c++) hold[c] = 0;
    for (int i = 0; i < 1200; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          lv[c]   = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 9);
        end
        hold[c]--;
      end
      if ($urandom_range(0, 19) == 0) md = 2'($urandom_range(0, 3));
      cl = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      cyc(lv, md, cl, ($urandom_range(0, 149) == 0));
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", n_cyc, 4'(exp_q.size()), 4'd0);
    n_chk++;
    if (n_ticks < 10) begin
      n_fail++;
      $display("FAIL tick_coverage: got %0d ticks expected at least 10", n_ticks);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
